// File: rtl/mem_arbiter_pkg.sv
// Shared constants and owner encoding for the kanade32 I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

  // Who the read data coming out of the RAM next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first grant logic with a saturating starvation counter that forces a
// fetch grant after STARVE_LIMIT consecutive denials.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;

  assign force_i = (starve_cnt == LIMIT);

  // Grants are held low during reset so nothing reaches the RAM.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (rst_n) begin
      d_gnt = d_req && !(i_req && force_i);
      i_gnt = i_req && !d_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch (I) and load/store (D) ports,
// routing the one-cycle-late read data back to the port that issued it.
//
// Handshake: a port drives req with addr/we/wdata and keeps them stable until
// it sees gnt high in the same cycle; the access happens on req && gnt. gnt is
// combinational from both reqs and the registered starve count, and a port may
// drop req without ever being granted. A granted read answers with a one-cycle
// rvalid pulse on the following cycle; stores produce no rvalid.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W       = mem_arbiter_pkg::DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  owner_e pend_q;
  owner_e pend_d;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // With no winner the RAM sees a harmless read of the fetch address.
  assign ram_address = d_gnt ? d_addr : i_addr;
  assign ram_wren    = d_gnt && d_we;
  assign ram_data    = d_wdata;

  always_comb begin
    pend_d = OWN_NONE;
    if (i_gnt) begin
      pend_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      pend_d = OWN_D;
    end
  end

  // Reset drops any in-flight read so no stale rvalid follows release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= OWN_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;
  assign i_rvalid = (pend_q == OWN_I);
  assign d_rvalid = (pend_q == OWN_D);

endmodule
